// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's memory-side and decode-side signals.
// The master modport is the controller itself; the slave modport is its surroundings.
interface fetch_ctrl_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, im_instr, out_ready,
    output im_addr, out_valid, out_instr, out_pc, fault
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, im_instr, out_ready,
    input  im_addr, out_valid, out_instr, out_pc, fault
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller at the IF/ID boundary: owns the PC, fetches from a
// combinational instruction memory and hands instructions to decode via valid/ready.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_outInstr;
  logic [31:0] r_outPc;
  logic        r_outValid;

  logic w_pcLegal;
  logic w_redirLegal;
  logic w_slotFree;

  // Word-index compare, so the range check trips before pc+4 could ever wrap.
  function automatic logic isLegal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr[31:2] < 30'(IMEM_WORDS));
  endfunction

  assign w_pcLegal    = isLegal(r_pc);
  assign w_redirLegal = isLegal(bus.redirect_pc);
  assign w_slotFree   = !r_outValid || bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_outValid <= 1'b0;
      r_outInstr <= NOP;
      r_outPc    <= 32'h0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything and flushes the output slot, accepted or not.
      r_pc       <= bus.redirect_pc;
      r_outValid <= 1'b0;
      case (r_state)
        FETCH:   if (!bus.fetch_en) r_state <= IDLE;
        FAULT:   if (w_redirLegal) r_state <= FETCH;
        default: r_state <= r_state;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.out_ready) r_outValid <= 1'b0;
          if (bus.fetch_en) r_state <= FETCH;
        end
        FETCH: begin
          if (!bus.fetch_en) begin
            r_state <= IDLE;
            if (bus.out_ready) r_outValid <= 1'b0;
          end else if (!w_pcLegal) begin
            r_state <= FAULT;
            if (bus.out_ready) r_outValid <= 1'b0;
          end else if (w_slotFree) begin
            r_outInstr <= bus.im_instr;
            r_outPc    <= r_pc;
            r_outValid <= 1'b1;
            r_pc       <= r_pc + 32'd4;
          end
        end
        FAULT: begin
          if (bus.out_ready) r_outValid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.im_addr   = r_pc;
  assign bus.out_valid = r_outValid;
  assign bus.out_instr = r_outInstr;
  assign bus.out_pc    = r_outPc;
  assign bus.fault     = (r_state == FAULT);

endmodule
